// File: rtl/stpu_run_if.sv
// ---------------------------------------------------------------------------
// stpu_run_if
// Purpose : Bundles the run-controller control/status signals so that the
//           controller and whatever drives it (bench or debug block) share
//           one connection.
// Signals : soft_rst_i  - pulse, restart the release sequence from HOLD
//           halt_i      - per-core halt report (level or pulse)
//           kick_i      - watchdog kick (only used with STPU_RUN_WDOG_EN)
//           core_rst_o  - per-core active-high reset
//           running_o   - controller is in RUN
//           done_o      - all cores halted
//           timeout_o   - run ended on budget or watchdog
//           wdog_o      - the timeout came from the watchdog
//           halt_mask_o - sticky per-core halt bits
//           cycle_cnt_o - run cycles elapsed
// Modports: master drives the inputs and observes status; slave is the
//           controller itself.
// ---------------------------------------------------------------------------
interface stpu_run_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic              soft_rst_i;
    logic [NUM_CH-1:0] halt_i;
    logic              kick_i;
    logic [NUM_CH-1:0] core_rst_o;
    logic              running_o;
    logic              done_o;
    logic              timeout_o;
    logic              wdog_o;
    logic [NUM_CH-1:0] halt_mask_o;
    logic [CNT_W-1:0]  cycle_cnt_o;

    modport master (
        output soft_rst_i, halt_i, kick_i,
        input  core_rst_o, running_o, done_o, timeout_o, wdog_o,
               halt_mask_o, cycle_cnt_o
    );

    modport slave (
        input  soft_rst_i, halt_i, kick_i,
        output core_rst_o, running_o, done_o, timeout_o, wdog_o,
               halt_mask_o, cycle_cnt_o
    );
endinterface

// File: rtl/stpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// stpu_run_ctrl
// Purpose : Run controller for the STPU SoPC. Releases per-core resets in a
//           staggered sequence, counts run cycles, and ends the run either
//           when every core has reported halt (DONE) or when the cycle
//           budget runs out (TIMEOUT).
// Ports   : clk  - system clock
//           rst  - synchronous reset, active-high
//           bus  - stpu_run_if.slave (soft_rst_i, halt_i, kick_i in;
//                  core_rst_o, running_o, done_o, timeout_o, wdog_o,
//                  halt_mask_o, cycle_cnt_o out)
// Option  : STPU_RUN_WDOG_EN - when defined, a kickable watchdog in RUN can
//           also end the run in TIMEOUT with wdog_o set. When undefined,
//           kick_i is ignored and wdog_o is tied to 0.
// ---------------------------------------------------------------------------
module stpu_run_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int RST_CYCLES  = 10,
    parameter int STAGGER     = 2,
    parameter int RUN_CYCLES  = 205,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    stpu_run_if.slave  bus
);
    // Edge that releases the last channel; hold_cnt only has to reach it.
    localparam int LAST_REL = RST_CYCLES + (NUM_CH - 1) * STAGGER;
    localparam int HOLD_W   = (LAST_REL + 1 > 2) ? $clog2(LAST_REL + 1) : 1;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CH-1:0]   halt_mask_q, halt_mask_d;
    logic [NUM_CH-1:0]   core_rst_q, core_rst_d;
    logic                wdog_q, wdog_d;

`ifdef STPU_RUN_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES + 1 > 2) ? $clog2(WDOG_CYCLES + 1) : 1;
    logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
`else
    logic                unused_wdog;
    assign unused_wdog = bus.kick_i ^ (WDOG_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        // Soft reset has exactly the same effect as rst.
        if (rst || bus.soft_rst_i) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            halt_mask_q <= '0;
            core_rst_q  <= '1;
            wdog_q      <= 1'b0;
`ifdef STPU_RUN_WDOG_EN
            wdog_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_mask_q <= halt_mask_d;
            core_rst_q  <= core_rst_d;
            wdog_q      <= wdog_d;
`ifdef STPU_RUN_WDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        halt_mask_d = halt_mask_q;
        core_rst_d  = core_rst_q;
        wdog_d      = wdog_q;
`ifdef STPU_RUN_WDOG_EN
        wdog_cnt_d  = wdog_cnt_q;
`endif
        case (state_q)
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                // Channel i leaves reset once the count reaches its slot.
                for (int i = 0; i < NUM_CH; i++) begin
                    core_rst_d[i] = (32'(hold_cnt_d) < 32'(RST_CYCLES + i * STAGGER));
                end
                if (32'(hold_cnt_d) == 32'(LAST_REL)) begin
                    state_d = S_RUN;
                end
`ifdef STPU_RUN_WDOG_EN
                wdog_cnt_d = '0;
`endif
            end
            S_RUN: begin
                cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
                halt_mask_d = halt_mask_q | bus.halt_i;
`ifdef STPU_RUN_WDOG_EN
                wdog_cnt_d  = bus.kick_i ? '0 : wdog_cnt_q + 1'b1;
`endif
                // DONE beats the budget, which beats the watchdog.
                if (&halt_mask_d) begin
                    state_d    = S_DONE;
                    core_rst_d = '1;
                end else if ((RUN_CYCLES != 0) &&
                             (cycle_cnt_q + CNT_W'(1) == CNT_W'(RUN_CYCLES))) begin
                    state_d    = S_TIMEOUT;
                    core_rst_d = '1;
                end
`ifdef STPU_RUN_WDOG_EN
                else if (32'(wdog_cnt_d) == 32'(WDOG_CYCLES)) begin
                    state_d    = S_TIMEOUT;
                    core_rst_d = '1;
                    wdog_d     = 1'b1;
                end
`endif
            end
            S_DONE, S_TIMEOUT: begin
                // Terminal: everything frozen, cores held in reset.
                core_rst_d = '1;
            end
            default: begin
                state_d     = S_HOLD;
                hold_cnt_d  = '0;
                cycle_cnt_d = '0;
                halt_mask_d = '0;
                core_rst_d  = '1;
                wdog_d      = 1'b0;
            end
        endcase
    end

    assign bus.core_rst_o  = core_rst_q;
    assign bus.running_o   = (state_q == S_RUN);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.timeout_o   = (state_q == S_TIMEOUT);
    assign bus.wdog_o      = wdog_q;
    assign bus.halt_mask_o = halt_mask_q;
    assign bus.cycle_cnt_o = cycle_cnt_q;

endmodule
